i2s_frame_rx: RTL and testbench

Captures stereo PCM from an I2S microphone link (Philips format, block is I2S slave) into the sys_clk domain and presents one decimated {left, right} sample pair at a time to the decimal-ASCII UART sender. Sits directly upstream of the UART sender. frame_data / frame_valid / frame_ready connect to its data / uart_ena / uart_ready. Decimation throttles the audio frame rate down to what the UART can print.

---
 rtl/i2s_frame_rx_pkg.sv | 25 ++
 rtl/i2s_sync.sv | 51 +++++
 rtl/i2s_frame_rx.sv | 125 ++++++++++++
 tb/tb_i2s_frame_rx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_frame_rx_pkg.sv
// ============================================================================
// i2s_frame_rx_pkg -- channel encodings, counter widths and helpers. Rev 1.0
// ============================================================================
`default_nettype none

package i2s_frame_rx_pkg;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  localparam int CNT_W    = 8;
  localparam int BITCNT_W = 6;

  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [BITCNT_W-1:0] bitcnt_t;

  localparam bitcnt_t BITCNT_MAX = '1;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : cnt_t'(v + 1'b1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_sync.sv
// ============================================================================
// i2s_sync -- 2-FF synchronizer with optional registered rising-edge pulse. Rev 1.0
// ============================================================================
`default_nettype none

module i2s_sync #(
  parameter bit EDGE = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic [1:0] sync_ff;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[0], din};
    end
  end

  assign dout = sync_ff[1];

  generate
    if (EDGE) begin : g_edge
      logic prev;
      logic rise_q;

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          prev   <= 1'b0;
          rise_q <= 1'b0;
        end else begin
          prev   <= sync_ff[1];
          rise_q <= sync_ff[1] & ~prev;
        end
      end

      assign rise = rise_q;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/i2s_frame_rx.sv
// ============================================================================
// i2s_frame_rx -- I2S slave capture, frame qualification and decimated
// hand-off of {left, right} pairs to the UART sender. Rev 1.0
// ============================================================================
`default_nettype none

module i2s_frame_rx
  import i2s_frame_rx_pkg::*;
#(
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = 32,
  parameter int DECIM       = 4800,
  parameter bit OFFSET      = 1'b1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     i2s_bclk,
  input  logic                     i2s_ws,
  input  logic                     i2s_sd,
  output logic [2*SAMPLE_BITS-1:0] frame_data,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [CNT_W-1:0]         overflow_cnt,
  output logic [CNT_W-1:0]         short_cnt
);

  localparam int slot_bits_unused = SLOT_BITS;
  localparam bitcnt_t SAMPLE_LAST = bitcnt_t'(SAMPLE_BITS - 1);
  localparam logic [15:0] DEC_LAST = 16'(DECIM - 1);
  localparam logic [SAMPLE_BITS-1:0] MSB_MASK =
    OFFSET ? {1'b1, {(SAMPLE_BITS-1){1'b0}}} : '0;

  logic rise, ws_s, sd_s;
  logic bclk_s_unused, ws_rise_unused, sd_rise_unused;

  i2s_sync #(.EDGE(1'b1)) u_sync_bclk (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(i2s_bclk),
    .dout(bclk_s_unused), .rise(rise)
  );
  i2s_sync #(.EDGE(1'b0)) u_sync_ws (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(i2s_ws),
    .dout(ws_s), .rise(ws_rise_unused)
  );
  i2s_sync #(.EDGE(1'b0)) u_sync_sd (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(i2s_sd),
    .dout(sd_s), .rise(sd_rise_unused)
  );

  logic                   ws_q, new_slot, left_start, left_good;
  bitcnt_t                bit_cnt, idx;
  logic [SAMPLE_BITS-1:0] sh_l, sh_r, sh_l_next, sh_r_next;
  logic [15:0]            dec_cnt;
  logic slot_full, capture, ws_edge, frame_done, frame_good;
  logic candidate, load, drop, short_evt;

  // idx is the position of the bit sampled at this rise within its slot
  assign idx        = new_slot ? '0 :
                      ((bit_cnt == BITCNT_MAX) ? bit_cnt : bitcnt_t'(bit_cnt + 1'b1));
  assign slot_full  = (idx >= SAMPLE_LAST);
  assign capture    = rise && (idx <= SAMPLE_LAST);
  assign ws_edge    = rise && (ws_s != ws_q);
  assign frame_done = ws_edge && (ws_q == WS_RIGHT);
  assign frame_good = frame_done && left_good && slot_full;
  assign candidate  = frame_good && (dec_cnt == DEC_LAST);
  assign load       = candidate && !frame_valid && !frame_ready;
  assign drop       = candidate && !load;
  assign short_evt  = frame_done && !frame_good && left_start;

  assign sh_l_next = (capture && (ws_q == WS_LEFT))  ? {sh_l[SAMPLE_BITS-2:0], sd_s} : sh_l;
  assign sh_r_next = (capture && (ws_q == WS_RIGHT)) ? {sh_r[SAMPLE_BITS-2:0], sd_s} : sh_r;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ws_q       <= WS_LEFT;
      new_slot   <= 1'b0;
      bit_cnt    <= '0;
      sh_l       <= '0;
      sh_r       <= '0;
      left_start <= 1'b0;
      left_good  <= 1'b0;
    end else if (rise) begin
      ws_q     <= ws_s;
      new_slot <= (ws_s != ws_q);
      bit_cnt  <= idx;
      sh_l     <= sh_l_next;
      sh_r     <= sh_r_next;
      // A left slot only qualifies if it began at a real 1->0 WS edge
      if (ws_edge && (ws_q == WS_LEFT)) begin
        left_good <= left_start && slot_full;
      end
      if (frame_done) begin
        left_start <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dec_cnt      <= '0;
      frame_data   <= '0;
      frame_valid  <= 1'b0;
      overflow_cnt <= '0;
      short_cnt    <= '0;
    end else begin
      if (frame_good) begin
        dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : 16'(dec_cnt + 1'b1);
      end
      if (load) begin
        frame_data  <= {sh_l ^ MSB_MASK, sh_r_next ^ MSB_MASK};
        frame_valid <= 1'b1;
      end else if (frame_ready) begin
        frame_valid <= 1'b0;
      end
      if (drop) begin
        overflow_cnt <= sat_inc(overflow_cnt);
      end
      if (short_evt) begin
        short_cnt <= sat_inc(short_cnt);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2s_frame_rx.sv
// ============================================================================
// tb_i2s_frame_rx -- directed bench: two DUT instances share one I2S bus. Rev 1.0
// ============================================================================
`default_nettype none

module tb_i2s_frame_rx;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic bclk = 1'b0, ws = 1'b0, sd = 1'b0;
  logic prev_bit = 1'b0;
  logic ready_man = 1'b0, ready_auto_a = 1'b0, ready_b = 1'b0;
  logic ready_a;
  bit   auto_a = 1'b0;
  int   half = 4;
  int   checks = 0, errors = 0;

  logic [31:0] fdata_a, fdata_b;
  logic        valid_a, valid_b;
  logic [7:0]  ovf_a, ovf_b, short_a, short_b;

  int          cnt_a = 0, cnt_b = 0;
  logic        pv_a = 1'b0, pv_b = 1'b0;
  logic [31:0] data_a [64];
  logic [31:0] data_b [64];

  logic [15:0] g2_l [8] = '{16'h1001, 16'h2002, 16'h3003, 16'h8000,
                            16'h5005, 16'h6006, 16'h7007, 16'h1357};
  logic [15:0] g2_r [8] = '{16'h0110, 16'h0220, 16'h0330, 16'h7FFF,
                            16'h0550, 16'h0660, 16'h0770, 16'h2468};

  assign ready_a = ready_man | ready_auto_a;

  always #5 sys_clk = ~sys_clk;

  i2s_frame_rx #(.SAMPLE_BITS(16), .SLOT_BITS(32), .DECIM(1), .OFFSET(1'b0)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .i2s_bclk(bclk), .i2s_ws(ws), .i2s_sd(sd),
    .frame_data(fdata_a), .frame_valid(valid_a), .frame_ready(ready_a),
    .overflow_cnt(ovf_a), .short_cnt(short_a)
  );

  i2s_frame_rx #(.SAMPLE_BITS(16), .SLOT_BITS(32), .DECIM(4), .OFFSET(1'b1)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .i2s_bclk(bclk), .i2s_ws(ws), .i2s_sd(sd),
    .frame_data(fdata_b), .frame_valid(valid_b), .frame_ready(ready_b),
    .overflow_cnt(ovf_b), .short_cnt(short_b)
  );

  // Record the data word seen at every rising edge of frame_valid
  initial forever begin
    @(negedge sys_clk);
    if (valid_a && !pv_a) begin
      if (cnt_a < 64) data_a[cnt_a] = fdata_a;
      cnt_a++;
    end
    pv_a = valid_a;
  end

  initial forever begin
    @(negedge sys_clk);
    if (valid_b && !pv_b) begin
      if (cnt_b < 64) data_b[cnt_b] = fdata_b;
      cnt_b++;
    end
    pv_b = valid_b;
  end

  initial forever begin
    @(negedge sys_clk);
    if (auto_a && valid_a) begin
      repeat (4) @(negedge sys_clk);
      ready_auto_a = 1'b1;
      @(negedge sys_clk);
      ready_auto_a = 1'b0;
      @(negedge sys_clk);
    end
  end

  initial forever begin
    @(negedge sys_clk);
    if (valid_b) begin
      repeat (4) @(negedge sys_clk);
      ready_b = 1'b1;
      @(negedge sys_clk);
      ready_b = 1'b0;
      @(negedge sys_clk);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    bclk = 1'b0; ws = 1'b0; sd = 1'b0; prev_bit = 1'b0;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  // One BCLK period; sd carries the previous stream bit (1-bit I2S delay)
  task automatic bclk_cycle(input logic c, input logic b, input bit pulse);
    bclk = 1'b0; ws = c; sd = prev_bit; prev_bit = b;
    repeat (half) @(negedge sys_clk);
    bclk = 1'b1;
    for (int i = 1; i <= half; i++) begin
      @(negedge sys_clk);
      if (pulse && i == 3) ready_man = 1'b1;
      if (pulse && i == 4) ready_man = 1'b0;
    end
  endtask

  task automatic send_slot(input logic c, input logic [15:0] w, input int k_from, input int k_to);
    for (int k = k_from; k < k_to; k++) begin
      bclk_cycle(c, (k < 16) ? w[4'(15 - k)] : 1'b0, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nl, input int nr);
    send_slot(1'b0, l, 0, nl);
    send_slot(1'b1, r, 0, nr);
  endtask

  initial begin
    int base_a, base_b;

    do_reset();
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_data", fdata_a, 32'h0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_short", 32'(short_a), 32'd0);

    // basic capture
    send_slot(1'b1, 16'h0, 0, 32);
    send_frame(16'h1234, 16'hABCD, 32, 32);
    bclk_cycle(1'b0, 1'b0, 1'b0);
    check("basic_valid", 32'(valid_a), 32'd1);
    check("basic_data", fdata_a, 32'h1234ABCD);
    ready_man = 1'b1;
    @(negedge sys_clk);
    ready_man = 1'b0;
    check("basic_ready_clr", 32'(valid_a), 32'd0);
    check("decim4_idle", 32'(valid_b), 32'd0);

    // decimation and offset binary
    do_reset();
    auto_a = 1'b1;
    base_a = cnt_a; base_b = cnt_b;
    send_slot(1'b1, 16'h0, 0, 32);
    for (int i = 0; i < 8; i++) send_frame(g2_l[i], g2_r[i], 32, 32);
    bclk_cycle(1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge sys_clk);
    auto_a = 1'b0;
    check("dec1_count", 32'(cnt_a - base_a), 32'd8);
    check("dec4_count", 32'(cnt_b - base_b), 32'd2);
    check("dec4_frame4_offset", data_b[base_b], 32'h0000FFFF);
    check("dec4_frame8_offset", data_b[base_b + 1], 32'h9357A468);
    check("dec1_frame4_raw", data_a[base_a + 3], 32'h80007FFF);
    check("dec1_ovf", 32'(ovf_a), 32'd0);
    check("dec4_ovf", 32'(ovf_b), 32'd0);

    // consumer busy
    do_reset();
    send_slot(1'b1, 16'h0, 0, 32);
    send_frame(16'h1111, 16'h2222, 32, 32);
    send_frame(16'h3333, 16'h4444, 32, 32);
    send_frame(16'h5555, 16'h6666, 32, 32);
    bclk_cycle(1'b0, 1'b0, 1'b0);
    check("busy_data", fdata_a, 32'h11112222);
    check("busy_ovf", 32'(ovf_a), 32'd2);
    check("busy_valid", 32'(valid_a), 32'd1);
    ready_man = 1'b1;
    @(negedge sys_clk);
    ready_man = 1'b0;
    check("busy_ready_clr", 32'(valid_a), 32'd0);
    send_slot(1'b0, 16'h0, 1, 32);
    send_slot(1'b1, 16'h7777, 0, 32);
    bclk_cycle(1'b0, 1'b0, 1'b1);
    check("samecyc_ovf", 32'(ovf_a), 32'd3);
    check("samecyc_data", fdata_a, 32'h11112222);
    check("samecyc_valid", 32'(valid_a), 32'd0);

    // overflow saturation, fast BCLK with 16-bit slots
    do_reset();
    half = 2;
    send_slot(1'b1, 16'h0, 0, 16);
    for (int i = 0; i < 300; i++) send_frame(16'(i) + 16'h0100, 16'hCAFE, 16, 16);
    bclk_cycle(1'b0, 1'b0, 1'b0);
    half = 4;
    check("sat_ovf", 32'(ovf_a), 32'd255);
    check("sat_data", fdata_a, 32'h0100CAFE);
    check("sat_short", 32'(short_a), 32'd0);

    // short left slot
    do_reset();
    base_a = cnt_a;
    send_slot(1'b1, 16'h0, 0, 32);
    send_frame(16'h0AAA, 16'h0BBB, 10, 32);
    send_frame(16'h5A5A, 16'hC3C3, 32, 32);
    bclk_cycle(1'b0, 1'b0, 1'b0);
    check("short_cnt_a", 32'(short_a), 32'd1);
    check("short_cnt_b", 32'(short_b), 32'd1);
    check("short_next_data", fdata_a, 32'h5A5AC3C3);
    check("short_next_count", 32'(cnt_a - base_a), 32'd1);

    // reset in the middle of a right slot
    do_reset();
    send_slot(1'b1, 16'h0, 0, 32);
    send_frame(16'h0F0F, 16'hF0F0, 32, 32);
    send_slot(1'b0, 16'h3C3C, 0, 1);
    check("pre_rst_valid", 32'(valid_a), 32'd1);
    send_slot(1'b0, 16'h3C3C, 1, 32);
    send_slot(1'b1, 16'h9696, 0, 10);
    #1 sys_rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(valid_a), 32'd0);
    check("midrst_data", fdata_a, 32'h0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    base_a = cnt_a;
    send_slot(1'b1, 16'h9696, 10, 32);
    send_frame(16'h6A6A, 16'h5B5B, 32, 32);
    bclk_cycle(1'b0, 1'b0, 1'b0);
    check("postrst_count", 32'(cnt_a - base_a), 32'd1);
    check("postrst_data", fdata_a, 32'h6A6A5B5B);
    check("postrst_short", 32'(short_a), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
